// File: rtl/ct_vfalu_pipe_pkg.sv
// Shared constants and the stage record for the VFALU pipe valid controller.
// Latency: none; this file holds only types and constants.
// Backpressure: none; this file holds only types and constants.
package ct_vfalu_pipe_pkg;

    localparam int LANES_DEF = 4;
    localparam int TAG_W_DEF = 7;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 8;
    localparam int LANES_MIN = 1;
    localparam int LANES_MAX = 16;

    // One pipe stage at the default lane and tag widths.
    // ct_vfalu_pipe_stage builds the same layout at its own widths.
    typedef struct packed {
        logic                 vld;
        logic [LANES_DEF-1:0] lane_mask;
        logic [TAG_W_DEF-1:0] tag;
    } stage_rec_t;

    function automatic logic depth_ok(input int depth);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
    endfunction

    function automatic logic lanes_ok(input int lanes);
        return (lanes >= LANES_MIN) && (lanes <= LANES_MAX);
    endfunction

endpackage

// File: rtl/ct_vfalu_pipe_stage.sv
// One registered pipe stage: valid bit, lane mask and tag, plus its clock enable.
// Latency: one cycle from prev_* to the outputs when the pipe advances.
// Backpressure: stall holds everything; flush clears the valid bit and leaves the payload alone.
module ct_vfalu_pipe_stage
    import ct_vfalu_pipe_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             prev_vld,
    input  logic [LANES-1:0] prev_lane_mask,
    input  logic [TAG_W-1:0] prev_tag,
    output logic             vld,
    output logic [LANES-1:0] lane_mask,
    output logic [TAG_W-1:0] tag,
    output logic             clk_en
);

    typedef struct packed {
        logic             vld;
        logic [LANES-1:0] lane_mask;
        logic [TAG_W-1:0] tag;
    } rec_t;

    rec_t rec_q;
    rec_t rec_d;
    logic advance;

    assign advance = ~stall & ~flush;

    // Next state: flush kills the valid bit, stall holds it.
    // The payload moves only when a valid op comes from the previous stage.
    always_comb begin
        rec_d = rec_q;
        if (flush) begin
            rec_d.vld = 1'b0;
        end else if (!stall) begin
            rec_d.vld = prev_vld;
        end
        if (advance && prev_vld) begin
            rec_d.lane_mask = prev_lane_mask;
            rec_d.tag       = prev_tag;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    // The clock runs when an op arrives or leaves. Stall turns it off.
    // Flush turns it on so the valid bit can clear. Reset turns it on unconditionally.
    assign clk_en    = rst | ((prev_vld | rec_q.vld) & (~stall | flush));

    assign vld       = rec_q.vld;
    assign lane_mask = rec_q.lane_mask;
    assign tag       = rec_q.tag;

endmodule

// File: rtl/ct_vfalu_pipe_vld_ctrl.sv
// Valid/pipedown controller for a DEPTH-stage VFALU pipe, with per-lane masks and tags.
// Latency: an op accepted in EX1 at cycle t reaches wb_* at cycle t+DEPTH-1.
// Backpressure: pipe_stall holds all stages and deasserts ex1_rdy and wb_vld. Flush has priority over stall and issue.
module ct_vfalu_pipe_vld_ctrl
    import ct_vfalu_pipe_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter int  LANES = LANES_DEF,
    parameter int  TAG_W = TAG_W_DEF,
    localparam int CNT_W = $clog2(DEPTH)
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic                   ex1_sel,
    input  logic [LANES-1:0]       ex1_lane_mask,
    input  logic [TAG_W-1:0]       ex1_tag,
    input  logic                   pipe_stall,
    input  logic                   pipe_flush,
    output logic                   ex1_rdy,
    output logic [DEPTH-1:0]       stage_pipedown,
    output logic [DEPTH-2:0]       stage_clk_en,
    output logic [DEPTH*LANES-1:0] stage_lane_vld,
    output logic                   wb_vld,
    output logic [LANES-1:0]       wb_lane_mask,
    output logic [TAG_W-1:0]       wb_tag,
    output logic [CNT_W-1:0]       inflight_cnt,
    output logic                   pipe_idle
);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("ct_vfalu_pipe_vld_ctrl: DEPTH %0d out of range", DEPTH);
    end
    if (!lanes_ok(LANES)) begin : g_bad_lanes
        $error("ct_vfalu_pipe_vld_ctrl: LANES %0d out of range", LANES);
    end

    // Index 0 is the combinational EX1 stage. Index k-1 is stage EXk.
    logic [DEPTH-1:0]            vld_all;
    logic [DEPTH-1:0][LANES-1:0] lane_all;
    logic [DEPTH-1:0][TAG_W-1:0] tag_all;
    logic                        ex1_acc;
    logic                        ex1_req;

    // An op with no active lanes carries no work, so it is never accepted.
    assign ex1_req     = ex1_sel & (|ex1_lane_mask);
    assign ex1_rdy     = ~pipe_stall & ~pipe_flush;
    assign ex1_acc     = ex1_req & ex1_rdy;

    assign vld_all[0]  = ex1_acc;
    assign lane_all[0] = ex1_lane_mask;
    assign tag_all[0]  = ex1_tag;

    for (genvar k = 1; k < DEPTH; k++) begin : g_stage
        ct_vfalu_pipe_stage #(
            .LANES (LANES),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk            (forever_cpuclk),
            .rst            (cpurst),
            .stall          (pipe_stall),
            .flush          (pipe_flush),
            .prev_vld       (vld_all[k-1]),
            .prev_lane_mask (lane_all[k-1]),
            .prev_tag       (tag_all[k-1]),
            .vld            (vld_all[k]),
            .lane_mask      (lane_all[k]),
            .tag            (tag_all[k]),
            .clk_en         (stage_clk_en[k-1])
        );
    end

    assign stage_pipedown = vld_all;

    // Lane masks for each stage, qualified by that stage's valid bit.
    always_comb begin
        stage_lane_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_lane_vld[i*LANES +: LANES] = lane_all[i] & {LANES{vld_all[i]}};
        end
    end

    // Count of valid registered stages. It peaks at DEPTH-1, so CNT_W bits always suffice.
    always_comb begin
        inflight_cnt = '0;
        for (int k = 1; k < DEPTH; k++) begin
            inflight_cnt = inflight_cnt + CNT_W'(vld_all[k]);
        end
    end

    // While stalled, the writeback payload keeps showing the held EXn contents.
    assign wb_vld       = vld_all[DEPTH-1] & ~pipe_stall;
    assign wb_lane_mask = lane_all[DEPTH-1];
    assign wb_tag       = tag_all[DEPTH-1];

    assign pipe_idle    = (inflight_cnt == '0) & ~ex1_req;

endmodule

// File: tb/tb_ct_vfalu_pipe_vld_ctrl.sv
module tb_ct_vfalu_pipe_vld_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DEPTH=3, LANES=4 instance
    logic       sel3, stall3, flush3;
    logic [3:0] mask3;
    logic [6:0] tag3;
    logic       rdy3, wbv3, idle3;
    logic [2:0] pd3;
    logic [1:0] ce3;
    logic [11:0] lv3;
    logic [3:0] wbm3;
    logic [6:0] wbt3;
    logic [1:0] cnt3;

    // DEPTH=5, LANES=8 instance
    logic       sel5, stall5, flush5;
    logic [7:0] mask5;
    logic [6:0] tag5;
    logic       rdy5, wbv5, idle5;
    logic [4:0] pd5;
    logic [3:0] ce5;
    logic [39:0] lv5;
    logic [7:0] wbm5;
    logic [6:0] wbt5;
    logic [2:0] cnt5;

    ct_vfalu_pipe_vld_ctrl #(.DEPTH(3), .LANES(4), .TAG_W(7)) u_d3 (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .ex1_sel        (sel3),
        .ex1_lane_mask  (mask3),
        .ex1_tag        (tag3),
        .pipe_stall     (stall3),
        .pipe_flush     (flush3),
        .ex1_rdy        (rdy3),
        .stage_pipedown (pd3),
        .stage_clk_en   (ce3),
        .stage_lane_vld (lv3),
        .wb_vld         (wbv3),
        .wb_lane_mask   (wbm3),
        .wb_tag         (wbt3),
        .inflight_cnt   (cnt3),
        .pipe_idle      (idle3)
    );

    ct_vfalu_pipe_vld_ctrl #(.DEPTH(5), .LANES(8), .TAG_W(7)) u_d5 (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .ex1_sel        (sel5),
        .ex1_lane_mask  (mask5),
        .ex1_tag        (tag5),
        .pipe_stall     (stall5),
        .pipe_flush     (flush5),
        .ex1_rdy        (rdy5),
        .stage_pipedown (pd5),
        .stage_clk_en   (ce5),
        .stage_lane_vld (lv5),
        .wb_vld         (wbv5),
        .wb_lane_mask   (wbm5),
        .wb_tag         (wbt5),
        .inflight_cnt   (cnt5),
        .pipe_idle      (idle5)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [7:0] mask;
        logic [6:0] tag;
    } exp_t;

    exp_t q3[$];
    exp_t q5[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic s, input logic [3:0] m, input logic [6:0] t);
        sel3  = s;
        mask3 = m;
        tag3  = t;
    endtask

    // Writeback monitors: pop the expected retirement on every wb_vld
    always @(negedge clk) begin
        if (wbv3) begin
            if (q3.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb3_unexpected: got tag %0h with none expected (cycle %0d)", wbt3, cyc);
            end else begin
                exp_t e;
                e = q3.pop_front();
                chk("wb3_cycle", cyc, e.cyc);
                chk("wb3_mask", wbm3, e.mask[3:0]);
                chk("wb3_tag", wbt3, e.tag);
            end
        end
    end

    always @(negedge clk) begin
        if (wbv5) begin
            if (q5.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb5_unexpected: got tag %0h with none expected (cycle %0d)", wbt5, cyc);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("wb5_cycle", cyc, e.cyc);
                chk("wb5_mask", wbm5, e.mask);
                chk("wb5_tag", wbt5, e.tag);
            end
        end
    end

    // Watchdog
    initial begin
        repeat (5000) @(posedge clk);
        tests++;
        fails++;
        $display("FAIL watchdog: got cycle %0d expected finish before 5000", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive3(1'b0, 4'h0, 7'h00);
        stall3 = 1'b0; flush3 = 1'b0;
        sel5 = 1'b0; mask5 = 8'h00; tag5 = 7'h00; stall5 = 1'b0; flush5 = 1'b0;

        // Reset: every clock enable is open, pipe is idle
        tick; tick; #1;
        chk("rst_clk_en3", ce3, 2'b11);
        chk("rst_clk_en5", ce5, 4'hF);
        chk("rst_idle3", idle3, 1'b1);
        rst = 1'b0;
        #1;
        chk("idle_pipedown3", pd3, 3'b000);
        chk("idle_wb_vld3", wbv3, 1'b0);
        chk("idle_wb_mask3", wbm3, 4'h0);
        chk("idle_wb_tag3", wbt3, 7'h00);
        chk("idle_cnt3", cnt3, 2'd0);
        chk("idle_idle3", idle3, 1'b1);
        chk("idle_clk_en3", ce3, 2'b00);
        chk("idle_pipedown5", pd5, 5'b00000);
        chk("idle_idle5", idle5, 1'b1);

        // Single issue
        tick;
        drive3(1'b1, 4'b0101, 7'h15);
        q3.push_back('{cyc: cyc + 2, mask: 8'h05, tag: 7'h15});
        #1;
        chk("single_acc", pd3, 3'b001);
        chk("single_rdy", rdy3, 1'b1);
        chk("single_busy", idle3, 1'b0);
        tick;
        drive3(1'b0, 4'h0, 7'h00);
        #1;
        chk("single_ex2", pd3, 3'b010);
        chk("single_cnt", cnt3, 2'd1);
        chk("single_lane_ex2", lv3[7:4], 4'b0101);
        chk("single_clk_en", ce3, 2'b11);
        tick; #1;
        chk("single_ex3", pd3, 3'b100);
        chk("single_wb_vld", wbv3, 1'b1);
        tick; #1;
        chk("single_idle", idle3, 1'b1);
        chk("single_empty", pd3, 3'b000);

        // Back-to-back stream of five ops
        for (int i = 1; i <= 5; i++) begin
            tick;
            drive3(1'b1, 4'hF, 7'(i));
            q3.push_back('{cyc: cyc + 2, mask: 8'h0F, tag: 7'(i)});
            #1;
            if (i == 2) chk("b2b_cnt1", cnt3, 2'd1);
            if (i == 3) chk("b2b_cnt2", cnt3, 2'd2);
            if (i == 5) chk("b2b_cnt_full", cnt3, 2'd2);
        end
        tick;
        drive3(1'b0, 4'h0, 7'h00);
        repeat (3) tick;
        #1;
        chk("b2b_drained", idle3, 1'b1);

        // Stall mid-flight: tag 1 is held in EX3 for three cycles
        tick;
        drive3(1'b1, 4'b0011, 7'h01);
        q3.push_back('{cyc: cyc + 5, mask: 8'h03, tag: 7'h01});
        tick;
        drive3(1'b1, 4'b1100, 7'h02);
        q3.push_back('{cyc: cyc + 5, mask: 8'h0C, tag: 7'h02});
        for (int s = 0; s < 3; s++) begin
            tick;
            stall3 = 1'b1;
            drive3(1'b1, 4'hF, 7'h7F);
            #1;
            chk("stall_wb_vld", wbv3, 1'b0);
            chk("stall_wb_tag", wbt3, 7'h01);
            chk("stall_wb_mask", wbm3, 4'b0011);
            chk("stall_rdy", rdy3, 1'b0);
            chk("stall_clk_en", ce3, 2'b00);
            chk("stall_pipedown", pd3, 3'b110);
        end
        tick;
        stall3 = 1'b0;
        drive3(1'b0, 4'h0, 7'h00);
        #1;
        chk("stall_release_tag1", wbt3, 7'h01);
        tick; #1;
        chk("stall_release_tag2", wbt3, 7'h02);
        repeat (2) tick;

        // Flush under stall: both ops are killed and never retire
        tick;
        drive3(1'b1, 4'b0001, 7'h33);
        tick;
        drive3(1'b1, 4'b0010, 7'h44);
        tick;
        drive3(1'b0, 4'h0, 7'h00);
        stall3 = 1'b1;
        flush3 = 1'b1;
        #1;
        chk("flush_clk_en", ce3, 2'b11);
        chk("flush_rdy", rdy3, 1'b0);
        chk("flush_wb_vld", wbv3, 1'b0);
        tick;
        stall3 = 1'b0;
        flush3 = 1'b0;
        #1;
        chk("flush_cnt", cnt3, 2'd0);
        chk("flush_pipedown", pd3, 3'b000);
        chk("flush_idle", idle3, 1'b1);
        repeat (3) tick;

        // DEPTH=5, LANES=8: a zero-mask issue is dropped
        tick;
        sel5 = 1'b1; mask5 = 8'h00; tag5 = 7'h03;
        #1;
        chk("zero_acc", pd5, 5'b00000);
        chk("zero_idle", idle5, 1'b1);
        tick;
        sel5 = 1'b0; tag5 = 7'h00;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("zero_pipedown", pd5, 5'b00000);
            chk("zero_cnt", cnt5, 3'd0);
            tick;
        end

        // DEPTH=5: single-lane op reaches writeback four cycles after issue
        sel5 = 1'b1; mask5 = 8'h80; tag5 = 7'h2A;
        q5.push_back('{cyc: cyc + 4, mask: 8'h80, tag: 7'h2A});
        #1;
        chk("d5_acc", pd5, 5'b00001);
        tick;
        sel5 = 1'b0; mask5 = 8'h00; tag5 = 7'h00;
        #1;
        chk("d5_ex2", pd5, 5'b00010);
        chk("d5_lane_ex2", lv5[15:8], 8'h80);
        tick; tick; #1;
        chk("d5_ex4_cnt", cnt5, 3'd1);
        repeat (4) tick;
        #1;

        chk("q3_drained", q3.size(), 0);
        chk("q5_drained", q5.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
